// File: rtl/load_align_unit.sv
// load_align_unit
//
// Purpose: fetch one or two 32-bit words from a word-addressed memory and
// return the load aligned and zero-filled, ready for a sign-extension stage.
// Byte, half and word loads use one memory beat; double loads use two beats
// (addr, then addr+4 wrapping modulo 2^32). A per-beat wait counter aborts a
// beat that is not answered within MEM_WAIT_MAX cycles and reports err.
//
// Configuration macro: LOAD_ALIGN_MISALIGN_TRAP_EN
//   defined   : misaligned half/word/double loads issue no memory request and
//               pulse err one cycle after start.
//   undefined : misaligned half ignores addr[0], misaligned word returns the
//               word rotated right by 8*addr[1:0], misaligned double ignores
//               addr[1:0]; err is raised only by a timeout.
//
// Ports:
//   CLK          in   clock, rising edge
//   CLR          in   synchronous active-high reset (beats start and memRdy)
//   start        in   load request, sampled only in IDLE
//   addr[31:0]   in   byte address of the load
//   dataSize[1:0]in   00 byte, 01 half, 10 word, 11 double
//   busy         out  high in every state except IDLE
//   memReq       out  memory read request
//   memAddr[31:0]out  word address of the current beat
//   memRdy       in   memory data valid for the current beat
//   memData[31:0]in   memory read word
//   Q[31:0]      out  aligned, zero-filled low data
//   Qhi[31:0]    out  second word of a double load, else 0
//   sizeOut[1:0] out  dataSize of the completed load
//   E            out  one-cycle completion pulse
//   err          out  one-cycle error pulse
//   o_dbg_state  out  current FSM state (debug visibility)
//
// Memory handshake: memReq is a request that stays high with memAddr stable
// until a cycle where memRdy is also high; the word on memData is taken on
// that rising edge and memReq is low in the following cycle. memRdy while
// memReq is low carries no meaning and is ignored.

module load_align_unit #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [1:0]  dataSize,
  output logic        busy,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memRdy,
  input  logic [31:0] memData,
  output logic [31:0] Q,
  output logic [31:0] Qhi,
  output logic [1:0]  sizeOut,
  output logic        E,
  output logic        err,
  output logic [1:0]  o_dbg_state
);

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD0  = 2'd1,
    S_RD1  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [WAIT_W-1:0]   r_wait;
  logic [31:0]         r_mem_addr;
  logic [31:0]         r_word0;
  logic [31:0]         r_q;
  logic [31:0]         r_qhi;
  logic [1:0]          r_size;
  logic [1:0]          r_size_out;
  logic [1:0]          r_lo;
  logic                r_err;

  logic                w_trap;
  logic                w_timeout;
  logic                w_in_beat;
  logic [63:0]         w_rot;
  logic [31:0]         w_aligned;

  // Misalignment trap: decided from the request itself while still in IDLE,
  // so a trapped load never leaves IDLE and never touches the memory.
`ifdef LOAD_ALIGN_MISALIGN_TRAP_EN
  logic w_misalign;
  always_comb begin
    w_misalign = 1'b0;
    unique case (dataSize)
      2'b01:   w_misalign = addr[0];
      2'b10:   w_misalign = |addr[1:0];
      2'b11:   w_misalign = |addr[2:0];
      default: w_misalign = 1'b0;
    endcase
  end
  assign w_trap = w_misalign;
`else
  assign w_trap = 1'b0;
`endif

  assign w_in_beat = (r_state == S_RD0) || (r_state == S_RD1);

  // Next-state logic.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start && !w_trap) w_next = S_RD0;
      end
      S_RD0: begin
        if (memRdy) begin
          w_next = (r_size == 2'b11) ? S_RD1 : S_DONE;
        end else if (r_wait == WAIT_LAST) begin
          w_next    = S_IDLE;
          w_timeout = 1'b1;
        end
      end
      S_RD1: begin
        if (memRdy) begin
          w_next = S_DONE;
        end else if (r_wait == WAIT_LAST) begin
          w_next    = S_IDLE;
          w_timeout = 1'b1;
        end
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Alignment of a single-beat load. The doubled word shifted right gives a
  // rotate; byte and half lanes are then just the low bits of that rotate.
  assign w_rot = {memData, memData} >> {r_lo, 3'b000};

  always_comb begin
    w_aligned = memData;
    unique case (r_size)
      2'b00:   w_aligned = {24'b0, w_rot[7:0]};
      2'b01:   w_aligned = r_lo[1] ? {16'b0, memData[31:16]} : {16'b0, memData[15:0]};
      2'b10:   w_aligned = w_rot[31:0];
      default: w_aligned = memData;
    endcase
  end

  // Datapath. Q/Qhi/sizeOut change only on the edge that enters DONE, so a
  // timed-out or trapped load leaves the previous result untouched.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_wait     <= '0;
      r_mem_addr <= '0;
      r_word0    <= '0;
      r_q        <= '0;
      r_qhi      <= '0;
      r_size     <= '0;
      r_size_out <= '0;
      r_lo       <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_timeout || ((r_state == S_IDLE) && start && w_trap);

      // Counter restarts whenever the beat state is entered or left.
      if (w_in_beat && (w_next == r_state)) r_wait <= r_wait + 1'b1;
      else                                  r_wait <= '0;

      unique case (r_state)
        S_IDLE: begin
          if (start && !w_trap) begin
            r_mem_addr <= {addr[31:2], 2'b00};
            r_lo       <= addr[1:0];
            r_size     <= dataSize;
          end
        end
        S_RD0: begin
          if (memRdy) begin
            if (r_size == 2'b11) begin
              r_word0    <= memData;
              r_mem_addr <= r_mem_addr + 32'd4;  // wraps modulo 2^32
            end else begin
              r_q        <= w_aligned;
              r_qhi      <= '0;
              r_size_out <= r_size;
            end
          end
        end
        S_RD1: begin
          if (memRdy) begin
            r_q        <= r_word0;
            r_qhi      <= memData;
            r_size_out <= r_size;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign memReq      = w_in_beat;
  assign memAddr     = r_mem_addr;
  assign Q           = r_q;
  assign Qhi         = r_qhi;
  assign sizeOut     = r_size_out;
  assign E           = (r_state == S_DONE);
  assign err         = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit
//
// Directed bench for load_align_unit. Driver tasks walk each load through its
// cycles and, alongside the stimulus, set the expected output values for the
// current cycle from the load/alignment rules; one compare process checks the
// DUT against those expectations on every falling edge. Literal checks after
// key loads pin the expected values independently.

module tb_load_align_unit;

  localparam int MAX = 15;

  // Clock / reset
  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic        start = 1'b0;
  logic [31:0] addr = '0;
  logic [1:0]  dataSize = '0;
  logic        memRdy = 1'b0;
  logic [31:0] memData = '0;

  logic        busy, memReq, E, err;
  logic [31:0] memAddr, Q, Qhi;
  logic [1:0]  sizeOut, dbg_state;

  always #5 CLK = ~CLK;

  load_align_unit #(.MEM_WAIT_MAX(MAX)) dut (
    .CLK(CLK), .CLR(CLR), .start(start), .addr(addr), .dataSize(dataSize),
    .busy(busy), .memReq(memReq), .memAddr(memAddr), .memRdy(memRdy),
    .memData(memData), .Q(Q), .Qhi(Qhi), .sizeOut(sizeOut), .E(E), .err(err),
    .o_dbg_state(dbg_state)
  );

  // Scoreboard state
  int n_tests = 0;
  int n_fail  = 0;
  int e_total = 0;
  int req_cnt = 0;
  logic [31:0] seen_q[$];

  // Expected outputs for the current cycle
  bit          m_en = 1'b0;
  logic        m_busy = 1'b0, m_req = 1'b0, m_E = 1'b0, m_err = 1'b0;
  bit          m_addr_chk = 1'b0;
  logic [31:0] m_addr = '0, m_Q = '0, m_Qhi = '0;
  logic [1:0]  m_size = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (m_en) begin
      check("busy",    {31'b0, busy},   {31'b0, m_busy});
      check("memReq",  {31'b0, memReq}, {31'b0, m_req});
      check("E",       {31'b0, E},      {31'b0, m_E});
      check("err",     {31'b0, err},    {31'b0, m_err});
      check("Q",       Q,               m_Q);
      check("Qhi",     Qhi,             m_Qhi);
      check("sizeOut", {30'b0, sizeOut},{30'b0, m_size});
      if (m_addr_chk) check("memAddr", memAddr, m_addr);
      if (E === 1'b1) e_total++;
    end
  end

  // Expected aligned low word from the load rules.
  function automatic logic [31:0] exp_q(input logic [31:0] a, input logic [1:0] sz,
                                        input logic [31:0] w);
    int sh;
    sh = 8 * int'(a[1:0]);
    case (sz)
      2'b00:   return (w >> sh) & 32'h0000_00FF;
      2'b01:   return a[1] ? (w >> 16) : (w & 32'h0000_FFFF);
      2'b10:   return (w >> sh) | (w << (32 - sh));
      default: return w;
    endcase
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle();
    m_busy = 1'b0; m_req = 1'b0; m_E = 1'b0; m_err = 1'b0; m_addr_chk = 1'b0;
  endtask

  // Entered at the first cycle of a beat; answers after d wait cycles, or
  // lets the beat time out when d >= MAX.
  task automatic beat(input logic [31:0] ba, input logic [31:0] w, input int d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < MAX; i++) begin
      m_busy = 1'b1; m_req = 1'b1; m_E = 1'b0; m_err = 1'b0;
      m_addr_chk = 1'b1; m_addr = ba;
      if (i == 0) seen_q.push_back(memAddr);
      if (memReq === 1'b1) req_cnt++;
      memRdy  = (i == d);
      memData = (i == d) ? w : $urandom;
      tick();
      memRdy  = 1'b0;
      memData = $urandom;
      if (i == d) begin
        ok = 1'b1;
        return;
      end
    end
    set_idle();
    m_err = 1'b1;
    tick();
    m_err = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input int d0, input int d1, input bit hold_start);
    logic [31:0] ba;
    bit ok;
    set_idle();
    start = 1'b1; addr = a; dataSize = sz;
    tick();
    start = hold_start;
`ifdef LOAD_ALIGN_MISALIGN_TRAP_EN
    if ((sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) ||
        (sz == 2'b11 && a[2:0] != 3'b000)) begin
      start = 1'b0;
      m_err = 1'b1;
      tick();
      m_err = 1'b0;
      return;
    end
`endif
    ba = {a[31:2], 2'b00};
    beat(ba, w0, d0, ok);
    if (!ok) begin
      start = 1'b0;
      return;
    end
    if (sz == 2'b11) begin
      beat(ba + 32'd4, w1, d1, ok);
      if (!ok) begin
        start = 1'b0;
        return;
      end
    end
    start = 1'b0;
    m_busy = 1'b1; m_req = 1'b0; m_E = 1'b1; m_addr_chk = 1'b0;
    m_Q    = (sz == 2'b11) ? w0 : exp_q(a, sz, w0);
    m_Qhi  = (sz == 2'b11) ? w1 : 32'h0;
    m_size = sz;
    tick();
    set_idle();
  endtask

  int  e0;
  bit  ok_b;

  initial begin
    // Reset
    tick();
    tick();
    m_en = 1'b1;
    set_idle();
    m_addr_chk = 1'b1; m_addr = '0;
    CLR = 1'b0;
    tick();
    m_addr_chk = 1'b0;

    // Byte load, lane 3, immediate memRdy
    seen_q.delete(); e0 = e_total;
    do_load(32'h0000_0103, 2'b00, 32'hAABB_CCDD, 32'h0, 0, 0, 1'b0);
    check("lit_byte_Q", Q, 32'h0000_00AA);
    check("lit_byte_size", {30'b0, sizeOut}, 32'h0);
    check("lit_byte_beats", seen_q.size(), 32'd1);
    if (seen_q.size() > 0) check("lit_byte_addr", seen_q[0], 32'h0000_0100);
    check("lit_byte_E_count", e_total - e0, 32'd1);

    // Half load, upper half, memRdy after two wait cycles
    do_load(32'h0000_0022, 2'b01, 32'h8001_FFFF, 32'h0, 2, 0, 1'b0);
    check("lit_half_Q", Q, 32'h0000_8001);
    check("lit_half_size", {30'b0, sizeOut}, 32'h1);

    // Double load crossing the top of the address space
    seen_q.delete(); e0 = e_total;
    do_load(32'hFFFF_FFF8, 2'b11, 32'h1111_1111, 32'h2222_2222, 0, 0, 1'b0);
    check("lit_dbl_Q", Q, 32'h1111_1111);
    check("lit_dbl_Qhi", Qhi, 32'h2222_2222);
    check("lit_dbl_beats", seen_q.size(), 32'd2);
    if (seen_q.size() > 1) begin
      check("lit_dbl_addr0", seen_q[0], 32'hFFFF_FFF8);
      check("lit_dbl_addr1", seen_q[1], 32'hFFFF_FFFC);
    end
    check("lit_dbl_E_count", e_total - e0, 32'd1);

    // Wrap of the second beat from 0xFFFFFFFC to 0
    seen_q.delete();
    do_load(32'hFFFF_FFFC, 2'b11, 32'h3333_3333, 32'h4444_4444, 1, 0, 1'b0);
`ifndef LOAD_ALIGN_MISALIGN_TRAP_EN
    if (seen_q.size() > 1) check("lit_wrap_addr1", seen_q[1], 32'h0000_0000);
`endif
    do_load(32'hFFFF_FFF8, 2'b11, 32'h1111_1111, 32'h2222_2222, 0, 0, 1'b0);

    // Word load never answered: timeout
    req_cnt = 0; e0 = e_total;
    do_load(32'h0000_0040, 2'b10, 32'h0, 32'h0, MAX, 0, 1'b0);
    check("lit_to_req_cycles", req_cnt, 32'd15);
    check("lit_to_E_count", e_total - e0, 32'd0);
    check("lit_to_Q_held", Q, 32'h1111_1111);
    check("lit_to_busy", {31'b0, busy}, 32'h0);

    // Misaligned word
    seen_q.delete();
    do_load(32'h0000_0001, 2'b10, 32'h4433_2211, 32'h0, 0, 0, 1'b0);
`ifdef LOAD_ALIGN_MISALIGN_TRAP_EN
    check("lit_mis_word_beats", seen_q.size(), 32'd0);
    check("lit_mis_word_Q_held", Q, 32'h1111_1111);
`else
    check("lit_mis_word_Q", Q, 32'h1144_3322);
`endif

    // Byte lanes 0..2, misaligned half, aligned/misaligned words, doubles
    for (int i = 0; i < 3; i++)
      do_load(32'h0000_0200 + i, 2'b00, 32'h8765_4321, 32'h0, i, 0, 1'b0);
    check("lit_lane2_Q", Q, 32'h0000_0065);
    do_load(32'h0000_0031, 2'b01, 32'hDEAD_BEEF, 32'h0, 1, 0, 1'b0);
`ifndef LOAD_ALIGN_MISALIGN_TRAP_EN
    check("lit_mis_half_Q", Q, 32'h0000_BEEF);
`endif
    do_load(32'h0000_0048, 2'b10, 32'hCAFE_F00D, 32'h0, 5, 0, 1'b0);
    check("lit_word_Q", Q, 32'hCAFE_F00D);
    check("lit_word_Qhi", Qhi, 32'h0);
    do_load(32'h0000_004B, 2'b10, 32'h4433_2211, 32'h0, 0, 0, 1'b0);
    do_load(32'h0000_0104, 2'b11, 32'h0102_0304, 32'h0506_0708, 3, 1, 1'b0);
    do_load(32'h0000_1000, 2'b11, 32'h9999_0000, 32'h0000_9999, 1, 4, 1'b1);
    do_load(32'h0000_1002, 2'b01, 32'h7FFF_1234, 32'h0, 2, 0, 1'b1);

    // Second beat of a double times out; result must stay as before
    do_load(32'h0000_2000, 2'b11, 32'hABCD_0000, 32'h0, 0, MAX, 1'b0);
    check("lit_rd1_to_Q_held", Q, 32'h0000_7FFF);

    // memRdy while no request is outstanding
    memRdy = 1'b1; memData = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) tick();
    memRdy = 1'b0;
    tick();

    // Reset during the second-beat wait, with start and memRdy also high
    e0 = e_total;
    start = 1'b1; addr = 32'h0000_3000; dataSize = 2'b11;
    tick();
    start = 1'b0;
    beat(32'h0000_3000, 32'h5555_AAAA, 0, ok_b);
    m_busy = 1'b1; m_req = 1'b1; m_E = 1'b0; m_err = 1'b0;
    m_addr_chk = 1'b1; m_addr = 32'h0000_3004;
    tick();
    tick();
    CLR = 1'b1; start = 1'b1; memRdy = 1'b1; memData = 32'h1234_5678;
    tick();
    CLR = 1'b0; start = 1'b0; memRdy = 1'b0;
    set_idle();
    m_Q = '0; m_Qhi = '0; m_size = '0;
    m_addr_chk = 1'b1; m_addr = '0;
    tick();
    m_addr_chk = 1'b0;
    check("lit_clr_E_count", e_total - e0, 32'd0);
    check("lit_clr_Q", Q, 32'h0);
    check("lit_clr_memAddr", memAddr, 32'h0);

    // Normal operation after reset
    do_load(32'h0000_0400, 2'b10, 32'h0BAD_C0DE, 32'h0, 0, 0, 1'b0);
    check("lit_post_clr_Q", Q, 32'h0BAD_C0DE);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
